quad_step_decoder: RTL and testbench

- Front-end stage upstream of the 3-bit up/down counter.
- Converts two asynchronous quadrature inputs (A/B, e.g. from a rotary encoder) into a direction level (up_down) and a one-cycle step enable (step).
- The downstream counter increments or decrements only on cycles where step=1.
- Synchronises and glitch-filters both channels, decodes Gray-sequence transitions and flags illegal double-bit jumps.

---
 rtl/quad_pkg.sv | 27 ++
 rtl/quad_chan_filter.sv | 53 +++++
 rtl/quad_step_decoder.sv | 106 ++++++++++
 tb/tb_quad_step_decoder.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// Shared encodings for the quadrature decoder: AB codes, FSM states and
// the up-sequence lookup used for direction decode.
package quad_pkg;

    localparam logic [1:0] AB_00 = 2'b00;
    localparam logic [1:0] AB_01 = 2'b01;
    localparam logic [1:0] AB_11 = 2'b11;
    localparam logic [1:0] AB_10 = 2'b10;

    typedef enum logic {
        ST_SETTLE = 1'b0,
        ST_RUN    = 1'b1
    } state_t;

    // Next code in the up direction; a down step is the inverse lookup.
    function automatic logic [1:0] next_up(input logic [1:0] ab);
        logic [1:0] nxt;
        case (ab)
            AB_00:   nxt = AB_01;
            AB_01:   nxt = AB_11;
            AB_11:   nxt = AB_10;
            default: nxt = AB_00;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/quad_chan_filter.sv
// One quadrature channel: multi-flop synchroniser followed by a debounce
// counter that only accepts a level held for FILTER_LEN consecutive cycles.
module quad_chan_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    input  logic load,
    output logic level
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   acc_q, acc_d;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];
    assign level  = acc_q;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        if (load) begin
            acc_d = synced;
            cnt_d = '0;
        end else if (synced == acc_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
            acc_d = synced;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            cnt_q  <= '0;
            acc_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
        end
    end

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature front end: filtered A/B channels decoded into step/up_down for
// the downstream counter, with illegal double-bit jumps flagged and counted.
module quad_step_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int ERR_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_in,
    input  logic             b_in,
    output logic             step,
    output logic             up_down,
    output logic             err,
    output logic [ERR_W-1:0] err_count,
    output logic             settled
);
    import quad_pkg::*;

    localparam int SETTLE_CYC = SYNC_STAGES + FILTER_LEN;
    localparam int SW         = $clog2(SETTLE_CYC + 1);

    state_t           state_q, state_d;
    logic [SW-1:0]    settle_cnt_q, settle_cnt_d;
    logic [1:0]       prev_ab_q, prev_ab_d;
    logic             step_q, step_d;
    logic             up_down_q, up_down_d;
    logic             err_q, err_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic             settled_q, settled_d;
    logic             acc_a, acc_b, load;
    logic [1:0]       acc_ab;

    assign load   = (state_q == ST_SETTLE);
    assign acc_ab = {acc_a, acc_b};

    quad_chan_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_a (
        .clk(clk), .reset(reset), .din(a_in), .load(load), .level(acc_a)
    );
    quad_chan_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_b (
        .clk(clk), .reset(reset), .din(b_in), .load(load), .level(acc_b)
    );

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        prev_ab_d    = acc_ab;
        step_d       = 1'b0;
        err_d        = 1'b0;
        up_down_d    = up_down_q;
        err_count_d  = err_count_q;
        settled_d    = settled_q;
        case (state_q)
            ST_SETTLE: begin
                settle_cnt_d = settle_cnt_q - 1'b1;
                if (settle_cnt_q <= SW'(1)) begin
                    state_d   = ST_RUN;
                    settled_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (acc_ab == next_up(prev_ab_q)) begin
                    step_d    = 1'b1;
                    up_down_d = 1'b1;
                end else if (prev_ab_q == next_up(acc_ab)) begin
                    step_d    = 1'b1;
                    up_down_d = 1'b0;
                end else if ((acc_ab ^ prev_ab_q) == 2'b11) begin
                    err_d = 1'b1;
                    if (err_count_q != '1)
                        err_count_d = err_count_q + 1'b1;
                end
            end
            default: state_d = ST_SETTLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_SETTLE;
            settle_cnt_q <= SW'(SETTLE_CYC);
            prev_ab_q    <= '0;
            step_q       <= 1'b0;
            up_down_q    <= 1'b1;
            err_q        <= 1'b0;
            err_count_q  <= '0;
            settled_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            prev_ab_q    <= prev_ab_d;
            step_q       <= step_d;
            up_down_q    <= up_down_d;
            err_q        <= err_d;
            err_count_q  <= err_count_d;
            settled_q    <= settled_d;
        end
    end

    assign step      = step_q;
    assign up_down   = up_down_q;
    assign err       = err_q;
    assign err_count = err_count_q;
    assign settled   = settled_q;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Bench for quad_step_decoder: expected step/err events are queued as inputs
// change and matched (kind, direction, exact cycle) when the DUT pulses.
module tb_quad_step_decoder;

    logic       clk = 1'b0;
    logic       reset, a_in, b_in;
    logic       step, up_down, err, settled;
    logic [7:0] err_count;

    quad_step_decoder #(.SYNC_STAGES(2), .FILTER_LEN(4), .ERR_W(8)) dut (
        .clk(clk), .reset(reset), .a_in(a_in), .b_in(b_in),
        .step(step), .up_down(up_down), .err(err),
        .err_count(err_count), .settled(settled)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit is_err;
        bit ud;
        int at;
    } ev_t;

    ev_t        q[$];
    int         tests = 0;
    int         fails = 0;
    logic [1:0] m_ab;
    bit         m_ud;

    function automatic int gpos(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Every step/err pulse must match the oldest queued expectation.
    task automatic monitor();
        ev_t e;
        forever begin
            @(negedge clk);
            if (step === 1'b1 || err === 1'b1) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_event cyc=%0d step=%b err=%b ud=%b, required no event",
                             cyc, step, err, up_down);
                end else begin
                    e = q.pop_front();
                    if (step !== !e.is_err || err !== e.is_err || up_down !== e.ud || cyc != e.at) begin
                        fails++;
                        $display("FAIL event got step=%b err=%b ud=%b cyc=%0d, required step=%b err=%b ud=%b cyc=%0d",
                                 step, err, up_down, cyc, !e.is_err, e.is_err, e.ud, e.at);
                    end
                end
            end
        end
    endtask

    task automatic set_ab(input logic a, input logic b, input int hold);
        logic [1:0] n;
        int d;
        n = {a, b};
        if ((n ^ m_ab) == 2'b11) begin
            q.push_back('{is_err: 1'b1, ud: m_ud, at: cyc + 7});
        end else if (n != m_ab) begin
            d    = (gpos(n) - gpos(m_ab) + 4) % 4;
            m_ud = (d == 1);
            q.push_back('{is_err: 1'b0, ud: m_ud, at: cyc + 7});
        end
        m_ab = n;
        a_in = a;
        b_in = b;
        tick(hold);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        q.delete();
        tick(2);
        reset = 1'b0;
        m_ab  = {a_in, b_in};
        m_ud  = 1'b1;
        tick(8);
    endtask

    task automatic drain(input string name);
        tick(10);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL %s missing_events got %0d pending, required 0", name, q.size());
        end
        q.delete();
    endtask

    task automatic test_reset();
        a_in = 1'b0; b_in = 1'b0;
        reset = 1'b1;
        tick(2);
        tests += 5;
        if (step !== 1'b0)      begin fails++; $display("FAIL reset_step got %b, required 0", step); end
        if (up_down !== 1'b1)   begin fails++; $display("FAIL reset_up_down got %b, required 1", up_down); end
        if (err !== 1'b0)       begin fails++; $display("FAIL reset_err got %b, required 0", err); end
        if (err_count !== 8'd0) begin fails++; $display("FAIL reset_err_count got %0d, required 0", err_count); end
        if (settled !== 1'b0)   begin fails++; $display("FAIL reset_settled got %b, required 0", settled); end
        reset = 1'b0;
        m_ab = 2'b00; m_ud = 1'b1;
        tick(8);
        tests++;
        if (settled !== 1'b1) begin fails++; $display("FAIL settled_after_reset got %b, required 1", settled); end
    endtask

    task automatic test_up();
        a_in = 1'b0; b_in = 1'b0;
        do_reset();
        set_ab(1'b0, 1'b1, 10);
        set_ab(1'b1, 1'b1, 10);
        set_ab(1'b1, 1'b0, 10);
        set_ab(1'b0, 1'b0, 10);
        drain("up_seq");
        tests++;
        if (err_count !== 8'd0) begin fails++; $display("FAIL up_err_count got %0d, required 0", err_count); end
    endtask

    task automatic test_down();
        a_in = 1'b0; b_in = 1'b0;
        do_reset();
        set_ab(1'b1, 1'b0, 10);
        set_ab(1'b1, 1'b1, 10);
        set_ab(1'b0, 1'b1, 10);
        set_ab(1'b0, 1'b0, 10);
        drain("down_seq");
        tests++;
        if (up_down !== 1'b0) begin fails++; $display("FAIL down_hold got %b, required 0", up_down); end
    endtask

    task automatic test_glitch();
        a_in = 1'b0; b_in = 1'b1;
        do_reset();
        a_in = 1'b1;
        tick(3);
        a_in = 1'b0;
        tick(12);
        tests++;
        if (up_down !== 1'b1) begin fails++; $display("FAIL glitch_up_down got %b, required 1", up_down); end
        set_ab(1'b1, 1'b1, 4);
        set_ab(1'b0, 1'b1, 12);
        drain("pulse4");
    endtask

    task automatic test_illegal();
        a_in = 1'b0; b_in = 1'b0;
        do_reset();
        set_ab(1'b1, 1'b1, 12);
        tests += 2;
        if (err_count !== 8'd1) begin fails++; $display("FAIL illegal_err_count got %0d, required 1", err_count); end
        if (up_down !== 1'b1)   begin fails++; $display("FAIL illegal_up_down got %b, required 1", up_down); end
        set_ab(1'b1, 1'b0, 12);
        drain("illegal_then_up");
    endtask

    task automatic test_settle_and_midreset();
        int r;
        int got;
        got  = -1;
        a_in = 1'b1; b_in = 1'b1;
        reset = 1'b1;
        q.delete();
        tick(2);
        reset = 1'b0;
        r = cyc;
        m_ab = 2'b11; m_ud = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (settled === 1'b1) begin
                got = cyc - r;
                break;
            end
        end
        tests++;
        if (got != 6) begin fails++; $display("FAIL settle_latency got %0d, required 6", got); end
        set_ab(1'b1, 1'b0, 12);
        set_ab(1'b1, 1'b1, 12);
        set_ab(1'b0, 1'b0, 12);
        tests++;
        if (err_count !== 8'd1) begin fails++; $display("FAIL pre_reset_err_count got %0d, required 1", err_count); end
        a_in = 1'b1;
        tick(2);
        reset = 1'b1;
        q.delete();
        tick(1);
        tests += 5;
        if (step !== 1'b0)      begin fails++; $display("FAIL mid_reset_step got %b, required 0", step); end
        if (up_down !== 1'b1)   begin fails++; $display("FAIL mid_reset_up_down got %b, required 1", up_down); end
        if (err !== 1'b0)       begin fails++; $display("FAIL mid_reset_err got %b, required 0", err); end
        if (err_count !== 8'd0) begin fails++; $display("FAIL mid_reset_err_count got %0d, required 0", err_count); end
        if (settled !== 1'b0)   begin fails++; $display("FAIL mid_reset_settled got %b, required 0", settled); end
        reset = 1'b0;
        m_ab = {a_in, b_in}; m_ud = 1'b1;
        tick(12);
        drain("after_mid_reset");
    endtask

    task automatic test_saturate();
        logic v;
        a_in = 1'b0; b_in = 1'b0;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            v = (i % 2 == 0);
            set_ab(v, v, 6);
        end
        drain("saturate");
        tests += 2;
        if (err_count !== 8'd255) begin fails++; $display("FAIL saturate_err_count got %0d, required 255", err_count); end
        if (up_down !== 1'b1)     begin fails++; $display("FAIL saturate_up_down got %b, required 1", up_down); end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog cyc=%0d, required completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; a_in = 1'b0; b_in = 1'b0;
        m_ab = 2'b00; m_ud = 1'b1;
        fork
            monitor();
        join_none
        tick(1);
        test_reset();
        test_up();
        test_down();
        test_glitch();
        test_illegal();
        test_settle_and_midreset();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
